// File: rtl/prefix_sum_stage_pkg.sv
// Shared constants for the wide prefix adder: default sizes and the
// bit positions of G and P inside each {G,P} pair from the tree.
package prefix_sum_stage_pkg;

   localparam int PFX_WIDTH    = 256;
   localparam int PFX_GROUP    = 8;
   localparam int PFX_TREESIZE = PFX_WIDTH / PFX_GROUP;
   localparam int PFX_G        = 1;
   localparam int PFX_P        = 0;

   function automatic bit is_pow2(input int n);
      return (n > 0) && ((n & (n - 1)) == 0);
   endfunction

endpackage

// File: rtl/prefix_sum_stage_group_sum.sv
// One prefix group: GROUP-bit a+b+c, carry out of the group is dropped
// because the prefix tree already supplies every group carry.
module group_sum #(
   parameter int GROUP = 8
) (
   input  logic [GROUP-1:0] a,
   input  logic [GROUP-1:0] b,
   input  logic             c,
   output logic [GROUP-1:0] sum
);

   assign sum = a + b + {{(GROUP-1){1'b0}}, c};

endmodule

// File: rtl/prefix_sum_stage.sv
// Final stage of the wide prefix adder: group carries from the tree,
// per-group sums, carry-out and overflow behind a 2-stage elastic pipe.
module prefix_sum_stage
   import prefix_sum_stage_pkg::*;
#(
   parameter int WIDTH    = PFX_WIDTH,
   parameter int GROUP    = PFX_GROUP,
   parameter int TREESIZE = WIDTH / GROUP
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WIDTH-1:0]      in_a,
   input  logic [WIDTH-1:0]      in_b,
   input  logic                  in_cin,
   input  logic [TREESIZE*2-1:0] in_grp,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WIDTH-1:0]      out_sum,
   output logic                  out_cout,
   output logic                  out_ovf
);

   if ((WIDTH % GROUP) != 0 || TREESIZE != WIDTH / GROUP ||
       !is_pow2(TREESIZE) || TREESIZE < 8) begin : g_bad_cfg
      $error("prefix_sum_stage: illegal WIDTH/GROUP/TREESIZE");
   end

   logic                  s1_valid;
   logic [WIDTH-1:0]      s1_a;
   logic [WIDTH-1:0]      s1_b;
   logic                  s1_cin;
   logic [TREESIZE*2-1:0] s1_grp;
   logic                  s2_valid;
   logic                  s1_adv;
   logic                  s2_adv;

   assign s2_adv    = !s2_valid || out_ready;
   assign s1_adv    = !s1_valid || s2_adv;
   assign in_ready  = s1_adv;
   assign out_valid = s2_valid;

   logic [TREESIZE-1:0] gc;
   logic [WIDTH-1:0]    sum_c;
   logic                cout_c;
   logic                ovf_c;

   for (genvar i = 0; i < TREESIZE; i++) begin : g_grp
      if (i == 0) begin : g_c0
         assign gc[i] = s1_cin;
      end else begin : g_ci
         assign gc[i] = s1_grp[2*(i-1)+PFX_G] |
                        (s1_grp[2*(i-1)+PFX_P] & s1_cin);
      end
      group_sum #(.GROUP(GROUP)) u_gs (
         .a   (s1_a[i*GROUP +: GROUP]),
         .b   (s1_b[i*GROUP +: GROUP]),
         .c   (gc[i]),
         .sum (sum_c[i*GROUP +: GROUP])
      );
   end

   assign cout_c = s1_grp[2*(TREESIZE-1)+PFX_G] |
                   (s1_grp[2*(TREESIZE-1)+PFX_P] & s1_cin);
   assign ovf_c  = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) &&
                   (sum_c[WIDTH-1] != s1_a[WIDTH-1]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
      end else if (s1_adv) begin
         s1_valid <= in_valid;
      end
   end

   // Payload needs no reset: it is only observed while s1_valid is set.
   always_ff @(posedge clk) begin
      if (s1_adv && in_valid) begin
         s1_a   <= in_a;
         s1_b   <= in_b;
         s1_cin <= in_cin;
         s1_grp <= in_grp;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid <= 1'b0;
         out_sum  <= '0;
         out_cout <= 1'b0;
         out_ovf  <= 1'b0;
      end else if (s2_adv) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            out_sum  <= sum_c;
            out_cout <= cout_c;
            out_ovf  <= ovf_c;
         end
      end
   end

endmodule
